bit_fusion_acc_pe: RTL
======================

// Module: bit_fusion_acc_pe
// PURPOSE
//  Parametrised successor of the fixed 16-brick PE. Multiplies N_BRICKS 2-bit activation/weight brick pairs.
//  Sums the brick products, shifts the sum left by a per-beat amount, and accumulates it over a burst of beats.
//  Beats use valid/ready handshakes in and out. Sits between the operand fetch buffers and the output
//  writeback in the Bit-blade array.
// PARAMETERS
//  N_BRICKS  16  number of 2-bit brick pairs per beat (power of 2, >=2)
//  SHIFT_W   4   width of i_shift_amount
//  ACC_W     32  accumulator/result width (must be >= SUM_W + 2**SHIFT_W - 1)
//  derived: SUM_W = 5 + clog2(N_BRICKS)  (9 at defaults)
// PORTS
//  i_clk           in   1            clock, rising edge
//  i_rst           in   1            synchronous reset, active-high
//  i_valid         in   1            input beat valid
//  o_ready         out  1            PE can accept a beat
//  i_activation    in   2*N_BRICKS   brick k = bits [2k+1:2k]
//  i_weight        in   2*N_BRICKS   brick k = bits [2k+1:2k]
//  i_A_signed      in   1            activation bricks are 2's complement (-2..1), else unsigned (0..3)
//  i_W_signed      in   1            weight bricks are 2's complement, else unsigned
//  i_shift_amount  in   SHIFT_W      left shift applied to this beat's brick sum
//  i_last          in   1            this beat closes the burst
//  i_flush         in   1            abandon the current burst
//  o_valid         out  1            result valid
//  i_ready         in   1            downstream accepts the result
//  o_sum           out  ACC_W        signed accumulated result
//  o_sat           out  1            result saturated (always 0 without macro)
// BEHAVIOUR
//  Reset (i_rst=1 at edge): state IDLE, acc=0, o_valid=0, o_sum=0, o_sat=0.
//   Reset mid-burst discards the partial sum.
//  Brick: 5-bit signed product of the two operands, each sign-extended or zero-extended per its flag.
//  Beat sum: SUM_W signed sum of all brick products, sign-extended to ACC_W, then shifted left (<<<) by i_shift_amount.
//  Flags and shift are sampled per beat and may differ between beats.
//  States:
//   IDLE: o_ready=1. Accept (i_valid&o_ready): acc <= term. Go to ACC, or to DONE if i_last.
//   ACC:  o_ready=1. Accept: acc <= acc+term. Stay in ACC, or go to DONE if i_last.
//   DONE: o_ready=0, o_valid=1, o_sum/o_sat held stable. On i_ready, go to IDLE; o_valid=0 next cycle.
//  Latency: the last beat accepted at edge t gives o_valid=1 and the final o_sum after edge t, i.e. from cycle t+1.
//  A single-beat burst (i_last on the first beat) is legal.
//  i_flush in IDLE/ACC: go to IDLE, acc=0, and the beat in that cycle is dropped (flush wins over accept).
//  i_flush in DONE: ignored.
//  i_valid while o_ready=0 is not accepted. The source holds the beat.
//  Overflow without macro: addition wraps modulo 2**ACC_W.
// CONFIGURATION
//  PE_ACC_SAT_EN defined: each add is done at ACC_W+1 bits and clamped to [-2**(ACC_W-1), 2**(ACC_W-1)-1].
//   o_sat is sticky for the burst, presented with o_valid, and cleared on return to IDLE.
//  PE_ACC_SAT_EN undefined: wrap arithmetic, o_sat tied 0.
// TESTING
//  1 unsigned: act=wt=32'hFFFF_FFFF, shift=0, i_last=1 -> next cycle o_valid=1, o_sum=144.
//  2 signed: act=32'hAAAA_AAAA (-2), wt=32'h5555_5555 (1), both signed -> o_sum=-32.
//    Mixed (A signed, W unsigned): act=wt=all 2'b11 -> o_sum=-48.
//  3 burst: beat1 all-ones unsigned, shift=4; beat2 same, shift=0, i_last -> o_sum=2448.
//  4 backpressure: i_ready=0 for 3 cycles in DONE -> o_valid, o_sum stable, o_ready=0.
//    Then i_ready=1 -> o_valid=0, o_ready=1 the cycle after.
//  5 flush/reset: beat1 (shift 4), then i_flush with a valid beat, then a single beat 144 -> o_sum=144.
//    Repeat with i_rst instead of i_flush -> o_sum=144.
//  6 ACC_W=12: all-ones unsigned, shift=4, last -> with PE_ACC_SAT_EN: o_sum=2047, o_sat=1.
//    Without the macro: o_sum=-1792, o_sat=0.

Source files
------------

// File: rtl/bit_fusion_acc_pe.sv
`default_nettype none
// ============================================================================
// Module   : bit_fusion_acc_pe
// Brief    : N_BRICKS x 2-bit brick multiply, shift and burst accumulate.
//            Define PE_ACC_SAT_EN to saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module bit_fusion_acc_pe #(
    parameter int N_BRICKS = 16,
    parameter int SHIFT_W  = 4,
    parameter int ACC_W    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [2*N_BRICKS-1:0]     i_activation,
    input  logic [2*N_BRICKS-1:0]     i_weight,
    input  logic                      i_A_signed,
    input  logic                      i_W_signed,
    input  logic [SHIFT_W-1:0]        i_shift_amount,
    input  logic                      i_last,
    input  logic                      i_flush,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [ACC_W-1:0]   o_sum,
    output logic                      o_sat
);

    localparam int c_sum_w  = 5 + $clog2(N_BRICKS);
    localparam int c_term_w = c_sum_w + 2**SHIFT_W - 1;
    // One spare bit above the wider of accumulator and shifted term so the
    // add can never overflow before clamping/truncation.
    localparam int c_wide_w = ((ACC_W > c_term_w) ? ACC_W : c_term_w) + 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [ACC_W-1:0]     w_acc_nxt;
    logic signed [c_sum_w-1:0]   w_beat_sum;
    logic signed [c_wide_w-1:0]  w_term;
    logic signed [c_wide_w-1:0]  w_base;
    logic signed [c_wide_w-1:0]  w_add;
    logic                        w_accept;
    logic                        w_flush;

    function automatic logic signed [c_sum_w-1:0] f_brick_sum(
        input logic [2*N_BRICKS-1:0] act,
        input logic [2*N_BRICKS-1:0] wt,
        input logic                  a_signed,
        input logic                  w_signed
    );
        logic signed [c_sum_w-1:0] sum;
        logic signed [2:0]         a3;
        logic signed [2:0]         w3;
        logic signed [5:0]         prod;
        sum = '0;
        for (int k = 0; k < N_BRICKS; k++) begin
            a3   = {a_signed & act[2*k+1], act[2*k +: 2]};
            w3   = {w_signed & wt[2*k+1],  wt[2*k +: 2]};
            prod = 6'(a3) * 6'(w3);
            sum  = sum + c_sum_w'(prod);
        end
        return sum;
    endfunction

    assign w_beat_sum = f_brick_sum(i_activation, i_weight, i_A_signed, i_W_signed);
    assign w_term     = c_wide_w'(w_beat_sum) <<< i_shift_amount;
    assign w_base     = (r_state == c_st_idle) ? '0 : c_wide_w'(r_acc);
    assign w_add      = w_base + w_term;
    assign w_flush    = i_flush & (r_state != c_st_done);
    assign w_accept   = i_valid & o_ready & ~i_flush;

`ifdef PE_ACC_SAT_EN
    localparam logic signed [c_wide_w-1:0] c_one     = 1;
    localparam logic signed [c_wide_w-1:0] c_acc_max = (c_one <<< (ACC_W-1)) - c_one;
    localparam logic signed [c_wide_w-1:0] c_acc_min = -(c_one <<< (ACC_W-1));

    logic r_sat;
    logic w_sat_now;

    always_comb begin
        w_sat_now = 1'b0;
        w_acc_nxt = w_add[ACC_W-1:0];
        if (w_add > c_acc_max) begin
            w_sat_now = 1'b1;
            w_acc_nxt = c_acc_max[ACC_W-1:0];
        end else if (w_add < c_acc_min) begin
            w_sat_now = 1'b1;
            w_acc_nxt = c_acc_min[ACC_W-1:0];
        end
    end

    // Sticky within a burst; a new burst starts from a clean flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_flush) begin
            r_sat <= 1'b0;
        end else if (r_state == c_st_done) begin
            if (i_ready) r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= ((r_state == c_st_idle) ? 1'b0 : r_sat) | w_sat_now;
        end
    end

    assign o_sat = r_sat;
`else
    assign w_acc_nxt = w_add[ACC_W-1:0];
    assign o_sat     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_acc: begin
                if (i_flush)       w_state_nxt = c_st_idle;
                else if (w_accept) w_state_nxt = i_last ? c_st_done : c_st_acc;
            end
            c_st_done: begin
                if (i_ready) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            c_st_idle, c_st_acc: o_ready = 1'b1;
            c_st_done:           o_valid = 1'b1;
            default: begin
                o_ready = 1'b0;
                o_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_flush) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_sum = r_acc;

endmodule
`default_nettype wire
